// File: rtl/iic_pkg.sv
// ---------------------------------------------------------------------------
// iic_pkg
// Shared types and helpers for the I2C target register block.
//   iic_state_t : protocol FSM states (exposed on the top's debug port)
//   IIC_ACK / IIC_NACK : bus level of the acknowledge bit
//   ptr_next()  : register pointer increment with wrap to 0
// ---------------------------------------------------------------------------
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ACK_ADDR,
        REG,
        ACK_REG,
        WDATA,
        ACK_WR,
        RDATA,
        RACK,
        WAIT_P
    } iic_state_t;

    localparam logic IIC_ACK  = 1'b0;
    localparam logic IIC_NACK = 1'b1;

    // The last legal index and every out-of-range index both wrap to 0.
    function automatic logic [7:0] ptr_next(input logic [7:0] ptr,
                                            input int unsigned nregs);
        if ({24'd0, ptr} >= (nregs - 32'd1)) begin
            return 8'h00;
        end
        return ptr + 8'd1;
    endfunction

endpackage

// File: rtl/iic_line_filter.sv
// ---------------------------------------------------------------------------
// iic_line_filter
// Conditions one open-drain bus line: 2-flop synchroniser, then a glitch
// filter that only changes its output after FILT_LEN equal samples, then
// single-cycle edge pulses on the filtered value.
// Ports:
//   clk, rst  : system clock, asynchronous active-high reset
//   i_line    : raw bus line
//   o_filt    : filtered level (resets to 1, the idle bus level)
//   o_rise    : one-cycle pulse on filtered 0->1
//   o_fall    : one-cycle pulse on filtered 1->0
// ---------------------------------------------------------------------------
module iic_line_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_filt,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0]          r_sync;
    logic [FILT_LEN-1:0] r_hist;
    logic                r_filt;
    logic                r_filt_d;

    // Everything resets to 1 so an idle bus produces no edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync   <= 2'b11;
            r_hist   <= '1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], i_line};
            r_hist   <= (r_hist << 1) | FILT_LEN'(r_sync[1]);
            if (&r_hist) begin
                r_filt <= 1'b1;
            end else if (~|r_hist) begin
                r_filt <= 1'b0;
            end
            r_filt_d <= r_filt;
        end
    end

    assign o_filt = r_filt;
    assign o_rise = r_filt & ~r_filt_d;
    assign o_fall = ~r_filt & r_filt_d;

endmodule

// File: rtl/iic_target_regs.sv
// ---------------------------------------------------------------------------
// iic_target_regs
// I2C target with a byte-addressed register file (NUM_REGS x 8 bit).
// Write: S, DEV_ADDR+W, pointer, data..., P (pointer auto-increments).
// Read : S, DEV_ADDR+R, data... (initiator ACKs to continue, NACKs to end);
//        a repeated START after the pointer byte keeps the pointer.
// Ports:
//   clk, rst     : system clock, asynchronous active-high reset
//   iic_scl      : bus SCL (never stretched)
//   iic_sda_i    : bus SDA as sensed
//   iic_sda_oe   : 1 = pull SDA low
//   regs         : register contents, byte k at [8k+7:8k]
//   wr_stb       : one-cycle pulse per committed in-range write
//   wr_addr/data : index and value of that write
//   busy         : addressed transaction in progress
//   o_dbg_state  : current FSM state
// ---------------------------------------------------------------------------
module iic_target_regs
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h3A,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iic_scl,
    input  logic                    iic_sda_i,
    output logic                    iic_sda_oe,
    output logic [8*NUM_REGS-1:0]   regs,
    output logic                    wr_stb,
    output logic [7:0]              wr_addr,
    output logic [7:0]              wr_data,
    output logic                    busy,
    output iic_state_t              o_dbg_state
);

    localparam int unsigned IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Line conditioning
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;

    iic_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk    (clk),
        .rst    (rst),
        .i_line (iic_scl),
        .o_filt (w_scl),
        .o_rise (w_scl_rise),
        .o_fall (w_scl_fall)
    );

    iic_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk    (clk),
        .rst    (rst),
        .i_line (iic_sda_i),
        .o_filt (w_sda),
        .o_rise (w_sda_rise),
        .o_fall (w_sda_fall)
    );

    // Both filters have identical latency, so w_scl is the SCL level that
    // was present when the SDA edge happened on the bus.
    logic w_start, w_stop;
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    // State
    iic_state_t r_state, w_state_nxt;
    logic [3:0] r_cnt,   w_cnt_nxt;     // bits received/sent in current byte
    logic [7:0] r_shift, w_shift_nxt;   // receive shifter
    logic [7:0] r_tx,    w_tx_nxt;      // transmit byte
    logic [7:0] r_ptr,   w_ptr_nxt;
    logic       r_oe,    w_oe_nxt;
    logic       r_busy,  w_busy_nxt;
    logic       r_rw,    w_rw_nxt;
    logic       r_mack,  w_mack_nxt;    // initiator's ACK/NACK after a read byte
    logic       w_commit;

    logic [7:0] r_regs [NUM_REGS];

    // Register read paths for the current pointer and the incremented one.
    logic [7:0] w_ptr_inc;
    logic       w_cur_in_range, w_inc_in_range;
    logic [7:0] w_rd_cur, w_rd_inc;

    assign w_ptr_inc      = ptr_next(r_ptr, NUM_REGS);
    assign w_cur_in_range = ({24'd0, r_ptr} < NUM_REGS);
    assign w_inc_in_range = ({24'd0, w_ptr_inc} < NUM_REGS);
    assign w_rd_cur = w_cur_in_range ? r_regs[r_ptr[IDXW-1:0]]     : 8'hFF;
    assign w_rd_inc = w_inc_in_range ? r_regs[w_ptr_inc[IDXW-1:0]] : 8'hFF;

    // Next-state logic. SDA drive only changes on an SCL falling edge, so
    // the change appears on the bus the cycle after the filtered fall.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_ptr_nxt   = r_ptr;
        w_oe_nxt    = r_oe;
        w_busy_nxt  = r_busy;
        w_rw_nxt    = r_rw;
        w_mack_nxt  = r_mack;
        w_commit    = 1'b0;

        if (w_start) begin
            w_state_nxt = ADDR;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_oe_nxt    = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                ADDR, REG, WDATA: begin
                    if (w_scl_rise && (r_cnt != 4'd8)) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall && (r_cnt == 4'd8)) begin
                        // Falling edge after the 8th bit opens the ACK slot.
                        w_cnt_nxt = 4'd0;
                        if (r_state == ADDR) begin
                            if (r_shift[7:1] == DEV_ADDR) begin
                                w_busy_nxt  = 1'b1;
                                w_rw_nxt    = r_shift[0];
                                w_oe_nxt    = 1'b1;
                                w_state_nxt = ACK_ADDR;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else if (r_state == REG) begin
                            w_ptr_nxt   = r_shift;
                            w_oe_nxt    = 1'b1;
                            w_state_nxt = ACK_REG;
                        end else begin
                            w_commit    = 1'b1;
                            w_ptr_nxt   = w_ptr_inc;
                            w_oe_nxt    = 1'b1;
                            w_state_nxt = ACK_WR;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_tx_nxt    = w_rd_cur;
                            w_oe_nxt    = ~w_rd_cur[7];
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = RDATA;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = REG;
                        end
                    end
                end
                ACK_REG, ACK_WR: begin
                    if (w_scl_fall) begin
                        w_oe_nxt    = 1'b0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = WDATA;
                    end
                end
                RDATA: begin
                    if (w_scl_rise && (r_cnt != 4'd8)) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = RACK;
                        end else begin
                            w_oe_nxt = ~r_tx[3'd7 - r_cnt[2:0]];
                        end
                    end
                end
                RACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = w_sda;
                    end else if (w_scl_fall) begin
                        if (r_mack == IIC_ACK) begin
                            w_ptr_nxt   = w_ptr_inc;
                            w_tx_nxt    = w_rd_inc;
                            w_oe_nxt    = ~w_rd_inc[7];
                            w_cnt_nxt   = 4'd0;
                            w_state_nxt = RDATA;
                        end else begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = WAIT_P;
                        end
                    end
                end
                default: begin
                    // IDLE and WAIT_P only leave on START/STOP.
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_shift <= 8'h00;
            r_tx    <= 8'h00;
            r_ptr   <= 8'h00;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_rw    <= 1'b0;
            r_mack  <= IIC_NACK;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_oe    <= w_oe_nxt;
            r_busy  <= w_busy_nxt;
            r_rw    <= w_rw_nxt;
            r_mack  <= w_mack_nxt;
        end
    end

    // Register file and write strobe. Out-of-range writes are ACKed on the
    // bus but leave the file untouched and raise no strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= 8'h00;
            end
            wr_stb  <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
        end else begin
            wr_stb <= 1'b0;
            if (w_commit && w_cur_in_range) begin
                r_regs[r_ptr[IDXW-1:0]] <= r_shift;
                wr_stb  <= 1'b1;
                wr_addr <= r_ptr;
                wr_data <= r_shift;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs[8*k +: 8] = r_regs[k];
    end

    assign iic_sda_oe  = r_oe;
    assign busy        = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_iic_target_regs.sv
// ---------------------------------------------------------------------------
// tb_iic_target_regs
// Directed bench: a bit-banged I2C initiator at 100 kHz (10 MHz clk) drives
// the target. Expected write strobes and read bytes go into queues when the
// stimulus is issued and are popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_iic_target_regs;
  import iic_pkg::*;

  localparam int unsigned NUM_REGS = 16;
  localparam int Q = 25;  // quarter SCL period in clk cycles

  // ---------------- clock / reset / bus ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_bus;

  logic                  iic_sda_oe;
  logic [8*NUM_REGS-1:0] regs;
  logic                  wr_stb;
  logic [7:0]            wr_addr;
  logic [7:0]            wr_data;
  logic                  busy;
  iic_state_t            dbg_state;

  always #50 clk = ~clk;

  // Open-drain wired-AND of initiator and target.
  assign sda_bus = m_sda & ~iic_sda_oe;

  iic_target_regs #(
    .DEV_ADDR (7'h3A),
    .NUM_REGS (NUM_REGS),
    .FILT_LEN (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .iic_scl     (m_scl),
    .iic_sda_i   (sda_bus),
    .iic_sda_oe  (iic_sda_oe),
    .regs        (regs),
    .wr_stb      (wr_stb),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // {addr, data} of expected write strobes
  logic [7:0]  rd_q[$];    // expected read bytes
  logic [7:0]  model [NUM_REGS];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int k = 0; k < NUM_REGS; k++) v[8*k +: 8] = model[k];
    return v;
  endfunction

  // Queue the effect of writing one data byte at a pointer.
  task automatic exp_write(input logic [7:0] ptr, input logic [7:0] d);
    if (ptr < NUM_REGS) begin
      exp_q.push_back({ptr, d});
      model[ptr[3:0]] = d;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_stb) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL wr_stb_unexpected observed=%0h expected=none", {wr_addr, wr_data});
      end else begin
        chk("wr_stb", {wr_addr, wr_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- initiator driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_bit(input logic b, input logic glitch, output logic r, output logic oe_s);
    m_sda = b;
    wait_clks(Q);
    m_scl = 1'b1;
    if (glitch) begin
      wait_clks(10);
      m_scl = 1'b0;
      wait_clks(1);
      m_scl = 1'b1;
      wait_clks(Q - 11);
    end else begin
      wait_clks(Q);
    end
    r    = sda_bus;
    oe_s = iic_sda_oe;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic m_start();
    m_sda = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic m_stop();
    m_sda = 1'b0;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    m_sda = 1'b1;
    wait_clks(2 * Q);
  endtask

  task automatic m_wr(input logic [7:0] d, input int glitch_bit, output logic ack);
    logic r, o;
    for (int i = 7; i >= 0; i--) m_bit(d[i], (i == glitch_bit), r, o);
    m_bit(1'b1, 1'b0, ack, o);
  endtask

  task automatic m_rd(input logic last, output logic [7:0] d, output logic oe_ack);
    logic r;
    logic o;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, 1'b0, r, o);
      d[i] = r;
    end
    m_bit(last, 1'b0, r, oe_ack);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       ack;
    logic       oe_s;
    logic       r;
    logic [7:0] d;

    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;

    wait_clks(5);
    rst = 1'b0;
    wait_clks(5);

    // Reset state
    chk("rst_oe", iic_sda_oe, 0);
    chk("rst_regs", regs, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_state", dbg_state, IDLE);

    // Write 0xA5, 0x5A at pointer 3
    m_start();
    m_wr(8'h74, -1, ack); chk("w1_ack_addr", ack, 0);
    chk("w1_busy", busy, 1);
    m_wr(8'h03, -1, ack); chk("w1_ack_reg", ack, 0);
    exp_write(8'h03, 8'hA5);
    m_wr(8'hA5, -1, ack); chk("w1_ack_d0", ack, 0);
    exp_write(8'h04, 8'h5A);
    m_wr(8'h5A, -1, ack); chk("w1_ack_d1", ack, 0);
    m_stop();
    chk("w1_busy_after_p", busy, 0);
    chk("w1_regs", regs, model_vec());

    // Random read from pointer 3: ACK then NACK
    m_start();
    m_wr(8'h74, -1, ack); chk("r1_ack_addr", ack, 0);
    m_wr(8'h03, -1, ack); chk("r1_ack_reg", ack, 0);
    m_start();
    m_wr(8'h75, -1, ack); chk("r1_ack_raddr", ack, 0);
    chk("r1_busy", busy, 1);
    rd_q.push_back(model[3]);
    rd_q.push_back(model[4]);
    m_rd(1'b0, d, oe_s);
    chk("r1_data0", d, rd_q.pop_front());
    chk("r1_rack0_released", oe_s, 0);
    m_rd(1'b1, d, oe_s);
    chk("r1_data1", d, rd_q.pop_front());
    chk("r1_rack1_released", oe_s, 0);
    wait_clks(Q);
    chk("r1_after_nack_oe", iic_sda_oe, 0);
    chk("r1_after_nack_state", dbg_state, WAIT_P);
    m_stop();
    chk("r1_busy_after_p", busy, 0);

    // Wrong address: no ACK, no strobe, not busy
    m_start();
    m_wr(8'h76, -1, ack); chk("wa_nack_addr", ack, 1);
    chk("wa_busy", busy, 0);
    m_wr(8'h01, -1, ack); chk("wa_nack_b1", ack, 1);
    m_wr(8'h55, -1, ack); chk("wa_nack_b2", ack, 1);
    m_stop();
    chk("wa_regs", regs, model_vec());

    // Pointer wrap: 15 -> 0
    m_start();
    m_wr(8'h74, -1, ack);
    m_wr(8'h0F, -1, ack);
    exp_write(8'h0F, 8'h11);
    m_wr(8'h11, -1, ack); chk("wrap_ack_d0", ack, 0);
    exp_write(8'h00, 8'h22);
    m_wr(8'h22, -1, ack); chk("wrap_ack_d1", ack, 0);
    m_stop();
    chk("wrap_regs", regs, model_vec());

    // Out-of-range write is ACKed but ignored; read returns 0xFF
    m_start();
    m_wr(8'h74, -1, ack); chk("oor_ack_addr", ack, 0);
    m_wr(8'h20, -1, ack); chk("oor_ack_reg", ack, 0);
    m_wr(8'h99, -1, ack); chk("oor_ack_data", ack, 0);
    m_stop();
    chk("oor_regs", regs, model_vec());
    m_start();
    m_wr(8'h74, -1, ack);
    m_wr(8'h20, -1, ack);
    m_start();
    m_wr(8'h75, -1, ack); chk("oor_ack_raddr", ack, 0);
    rd_q.push_back(8'hFF);
    m_rd(1'b1, d, oe_s);
    chk("oor_read", d, rd_q.pop_front());
    m_stop();

    // One-clk SCL glitch during a data bit is filtered out
    m_start();
    m_wr(8'h74, -1, ack);
    m_wr(8'h06, -1, ack);
    exp_write(8'h06, 8'hC3);
    m_wr(8'hC3, 5, ack); chk("gl_ack", ack, 0);
    m_stop();
    chk("gl_regs", regs, model_vec());

    // STOP in the middle of a data byte leaves the register file alone
    m_start();
    m_wr(8'h74, -1, ack);
    m_wr(8'h07, -1, ack);
    for (int i = 0; i < 4; i++) m_bit(1'b1, 1'b0, r, oe_s);
    m_stop();
    chk("ab_busy", busy, 0);
    chk("ab_state", dbg_state, IDLE);
    chk("ab_regs", regs, model_vec());

    // Asynchronous reset while the target drives a 0 data bit
    m_start();
    m_wr(8'h74, -1, ack);
    m_wr(8'h03, -1, ack);
    m_start();
    m_wr(8'h75, -1, ack);
    m_bit(1'b1, 1'b0, r, oe_s);   // bit 7 of 0xA5
    chk("ar_bit7", r, 1);
    m_sda = 1'b1;
    wait_clks(Q);
    m_scl = 1'b1;
    wait_clks(Q);
    chk("ar_oe_driving_bit6", iic_sda_oe, 1);
    #10;
    rst = 1'b1;
    #1;
    chk("ar_oe_async", iic_sda_oe, 0);
    chk("ar_regs_async", regs, 0);
    chk("ar_busy_async", busy, 0);
    for (int k = 0; k < NUM_REGS; k++) model[k] = 8'h00;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(10);

    // Target works again after the reset
    m_start();
    m_wr(8'h74, -1, ack); chk("pr_ack_addr", ack, 0);
    m_wr(8'h01, -1, ack);
    exp_write(8'h01, 8'h3C);
    m_wr(8'h3C, -1, ack); chk("pr_ack_data", ack, 0);
    m_stop();
    chk("pr_regs", regs, model_vec());

    wait_clks(5);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iic_target_regs.md
Name: iic_target_regs

Overview:
- I2C target (responder) with a small byte-addressed register file, clocked from the 10 MHz control clock.
- Lets an external I2C initiator (board MCU, debug bridge, or the team's own I2C master in loopback) read and write AimBot runtime configuration.
- Presents the register contents to the fabric and emits a one-cycle strobe for every committed write.

Parameters:
- DEV_ADDR, 7'h3A, 7-bit target address.
- NUM_REGS, 16, number of 8-bit registers; legal range 2..256.
- FILT_LEN, 3, consecutive identical synchronised samples required before SCL/SDA change their filtered value.

Ports:
- clk  input  1  system clock (10 MHz nominal).
- rst  input  1  asynchronous reset, active-high.
- iic_scl  input  1  bus SCL; the target never stretches the clock.
- iic_sda_i  input  1  bus SDA as sensed.
- iic_sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- regs  output  8*NUM_REGS  register contents; byte k at bits [8k+7:8k].
- wr_stb  output  1  one-cycle pulse when a data byte is written.
- wr_addr  output  8  register index of that write.
- wr_data  output  8  byte written.
- busy  output  1  1 from START addressed to DEV_ADDR until STOP or next START.

Behaviour:
- Reset: iic_sda_oe=0, regs all 0x00, wr_stb=0, wr_addr=0, wr_data=0, busy=0, pointer=0, FSM=IDLE. Reset is asynchronous and takes effect mid-transfer; SDA is released immediately.
- Input conditioning:
  - 2-flop synchroniser on SCL and SDA.
  - Glitch filter changes a filtered value only after FILT_LEN equal samples.
  - Edges are detected on the filtered values.
- Bus events:
  - START: filtered SDA falls while SCL=1.
  - STOP: filtered SDA rises while SCL=1.
  - Either event, in any state, aborts the current byte, resets the bit counter and releases SDA.
  - START enters ADDR. STOP enters IDLE with busy=0.
- Bit timing:
  - Sample SDA on SCL rising edge, MSB first.
  - The target changes iic_sda_oe only on the clk cycle after a filtered SCL falling edge.
- FSM:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Addr[7:1]==DEV_ADDR: busy=1, go to ACK_ADDR.
    - Otherwise go to IDLE (no ACK; wait for next START).
  - ACK_ADDR: drive low for one SCL period.
    - R/W=0 goes to REG.
    - R/W=1 loads the output shifter from the register at the pointer and goes to RDATA.
  - REG: shift 8 bits into the pointer, then ACK_REG (drive low), then WDATA.
  - WDATA: shift 8 bits, then ACK_WR (drive low).
    - The write commits on the SCL falling edge that starts the ACK: wr_stb=1 for one cycle with wr_addr and wr_data.
    - The pointer increments; go to WDATA.
  - RDATA: drive the shifter MSB first (oe=~bit), then RACK: release SDA and sample the initiator bit on SCL rising.
    - ACK (0): pointer increments, reload the shifter, go to RDATA.
    - NACK (1): go to WAIT_P, released until STOP or START.
- Pointer:
  - Increments with wrap: NUM_REGS-1 wraps to 0.
  - A REG byte >= NUM_REGS is still ACKed and stored. Writes to out-of-range indices are ACKed, but regs are unchanged and no wr_stb fires. Reads from them return 0xFF.
  - When that pointer increments, it wraps to 0 (out-of-range + 1 → 0).
- Repeated START after REG (combined write-then-read) keeps the pointer. This is the standard random-read sequence.
- Fabric has no write port to regs; regs change only via I2C or reset.

Decomposition:
- Shared package iic_pkg:
  - FSM state enum: IDLE, ADDR, ACK_ADDR, REG, ACK_REG, WDATA, ACK_WR, RDATA, RACK, WAIT_P.
  - Constants IIC_ACK=1'b0 and IIC_NACK=1'b1.
- One sub-module iic_line_filter, instanced twice for SCL and SDA. It contains the synchroniser, FILT_LEN filter and rise/fall pulses.
- START/STOP detection and the FSM stay in the top module.

Test Plan:
- Write: initiator at 100 kHz sends S, 0x74, 0x03, 0xA5, 0x5A, P.
  - All four bytes ACKed.
  - wr_stb fires twice: (3, 0xA5) then (4, 0x5A).
  - regs[3]=0xA5, regs[4]=0x5A; busy returns 0 after P.
- Random read: after the write above, S, 0x74, 0x03, Sr, 0x75, read 2 bytes ACK then NACK, P.
  - Data returned: 0xA5, 0x5A.
  - SDA released during both RACK bits and after NACK.
- Wrong address and wrap:
  - S, 0x76, ... → no ACK (SDA stays high), no wr_stb, busy=0.
  - S, 0x74, 0x0F, 0x11, 0x22, P → regs[15]=0x11, regs[0]=0x22.
- Out-of-range: S, 0x74, 0x20, 0x99, P.
  - All bytes ACKed; no wr_stb; regs unchanged.
  - A read at pointer 0x20 returns 0xFF.
- Glitch and abort:
  - A 1-clk low pulse on SCL during a data bit is ignored (byte still correct).
  - A STOP mid-byte during WDATA leaves regs unchanged.
  - Asserting rst mid-read forces iic_sda_oe=0 asynchronously and clears regs to 0x00.
